// File: rtl/leiwand_rv32_wb_interconnect.sv
// leiwand_rv32_wb_interconnect
// ----------------------------------------------------------------------------
// Single-master, N-slave pipelined Wishbone interconnect for leiwand_rv32_core.
// Table-driven address decode, one outstanding transaction, bus-error response
// for unmapped addresses and a per-transaction ack timeout.
//
// Handshake: a master request is (m_wb_stb && m_wb_cyc); it is accepted in a
// cycle where m_wb_stall is low. A response is one cycle of m_wb_ack (with
// m_wb_data_in valid) or one cycle of m_wb_err. m_wb_data_in is 0 otherwise.
//
// Ports
//   clk, reset           clock (rising edge), async active-low reset
//   m_wb_*               master side (stb/cyc/we/addr/data_out in,
//                        data_in/ack/err/stall out)
//   s_wb_stb             per-slave strobe
//   s_wb_cyc/we/addr/data_out  broadcast copies of the master signals
//   s_wb_data_in         packed slave read data, slave i at [i*MEM_WIDTH +: MEM_WIDTH]
//   s_wb_ack, s_wb_stall per-slave ack / stall
//   err_addr             address of the most recent errored transaction
//   dbg_state_o          current FSM state (IDLE=0, WAIT_ACK=1, ERR_RESP=2)
// ----------------------------------------------------------------------------
module leiwand_rv32_wb_interconnect #(
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned MEM_WIDTH      = 32,
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_BASE = {32'h20400000, 32'h10000000},
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZE = {32'h00004000, 32'h00004000},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            m_wb_stb,
    input  logic                            m_wb_cyc,
    input  logic                            m_wb_we,
    input  logic [MEM_WIDTH-1:0]            m_wb_addr,
    input  logic [MEM_WIDTH-1:0]            m_wb_data_out,
    output logic [MEM_WIDTH-1:0]            m_wb_data_in,
    output logic                            m_wb_ack,
    output logic                            m_wb_err,
    output logic                            m_wb_stall,
    output logic [NUM_SLAVES-1:0]           s_wb_stb,
    output logic                            s_wb_cyc,
    output logic                            s_wb_we,
    output logic [MEM_WIDTH-1:0]            s_wb_addr,
    output logic [MEM_WIDTH-1:0]            s_wb_data_out,
    input  logic [NUM_SLAVES*MEM_WIDTH-1:0] s_wb_data_in,
    input  logic [NUM_SLAVES-1:0]           s_wb_ack,
    input  logic [NUM_SLAVES-1:0]           s_wb_stall,
    output logic [MEM_WIDTH-1:0]            err_addr,
    output logic [1:0]                      dbg_state_o
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_ERR_RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;

    // ------------------------------------------------------------------
    // Address decode. Windows are compared one bit wider than the bus so a
    // window ending exactly at 2^MEM_WIDTH does not wrap to zero.
    // ------------------------------------------------------------------
    logic [NUM_SLAVES-1:0] win_hit;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
        localparam logic [MEM_WIDTH:0] WIN_LO = {1'b0, SLAVE_BASE[g*MEM_WIDTH +: MEM_WIDTH]};
        localparam logic [MEM_WIDTH:0] WIN_HI = WIN_LO + {1'b0, SLAVE_SIZE[g*MEM_WIDTH +: MEM_WIDTH]};
        assign win_hit[g] = ({1'b0, m_wb_addr} >= WIN_LO) && ({1'b0, m_wb_addr} < WIN_HI);
    end

    logic                 hit;
    logic [SEL_W-1:0]     hit_idx;
    logic                 hit_stall;
    logic                 sel_ack;
    logic [MEM_WIDTH-1:0] sel_data;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        hit_stall = 1'b0;
        sel_ack   = 1'b0;
        sel_data  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                hit       = 1'b1;
                hit_idx   = SEL_W'(i);
                hit_stall = s_wb_stall[i];
            end
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (SEL_W'(i) == sel_q) begin
                sel_ack  = s_wb_ack[i];
                sel_data = s_wb_data_in[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    logic [NUM_SLAVES-1:0] stb_vec;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        err_addr_d   = err_addr_q;
        addr_d       = addr_q;
        stb_vec      = '0;
        m_wb_ack     = 1'b0;
        m_wb_err     = 1'b0;
        m_wb_stall   = 1'b0;
        m_wb_data_in = '0;

        case (state_q)
            S_IDLE: begin
                if (m_wb_stb && m_wb_cyc) begin
                    if (hit) begin
                        stb_vec    = NUM_SLAVES'(1) << hit_idx;
                        m_wb_stall = hit_stall;
                        if (!hit_stall) begin
                            sel_d   = hit_idx;
                            cnt_d   = '0;
                            addr_d  = m_wb_addr;
                            state_d = S_WAIT_ACK;
                        end
                    end else begin
                        err_addr_d = m_wb_addr;
                        state_d    = S_ERR_RESP;
                    end
                end
            end

            S_WAIT_ACK: begin
                m_wb_stall = 1'b1;
                // Dropping cyc abandons the transaction silently.
                if (!m_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (sel_ack) begin
                    m_wb_ack     = 1'b1;
                    m_wb_data_in = sel_data;
                    state_d      = S_IDLE;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    err_addr_d = addr_q;
                    state_d    = S_ERR_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_ERR_RESP: begin
                m_wb_stall = 1'b1;
                m_wb_err   = m_wb_cyc;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // While reset is held no slave may see a strobe, even though the stall
    // path still reflects the decoded slave.
    assign s_wb_stb = reset ? stb_vec : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            err_addr_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
            addr_q     <= addr_d;
        end
    end

    assign s_wb_cyc      = m_wb_cyc;
    assign s_wb_we       = m_wb_we;
    assign s_wb_addr     = m_wb_addr;
    assign s_wb_data_out = m_wb_data_out;
    assign err_addr      = err_addr_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_leiwand_rv32_wb_interconnect.sv
// Testbench for leiwand_rv32_wb_interconnect (TIMEOUT_CYCLES = 4).
module tb_leiwand_rv32_wb_interconnect;

  localparam int NS = 2;
  localparam int W  = 32;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT signals ----------------
  logic          m_stb = 0, m_cyc = 0, m_we = 0;
  logic [W-1:0]  m_addr = '0, m_wdata = '0;
  logic [W-1:0]  m_rdata;
  logic          m_ack, m_err, m_stall;
  logic [NS-1:0] s_stb;
  logic          s_cyc, s_we;
  logic [W-1:0]  s_addr, s_wdata;
  logic [NS*W-1:0] s_data = '0;
  logic [NS-1:0] s_ack = '0, s_stall = '0;
  logic [W-1:0]  err_addr;
  logic [1:0]    dbg_state;

  leiwand_rv32_wb_interconnect #(
    .NUM_SLAVES(NS), .MEM_WIDTH(W),
    .SLAVE_BASE({32'h20400000, 32'h10000000}),
    .SLAVE_SIZE({32'h00004000, 32'h00004000}),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(rst_n),
    .m_wb_stb(m_stb), .m_wb_cyc(m_cyc), .m_wb_we(m_we),
    .m_wb_addr(m_addr), .m_wb_data_out(m_wdata), .m_wb_data_in(m_rdata),
    .m_wb_ack(m_ack), .m_wb_err(m_err), .m_wb_stall(m_stall),
    .s_wb_stb(s_stb), .s_wb_cyc(s_cyc), .s_wb_we(s_we),
    .s_wb_addr(s_addr), .s_wb_data_out(s_wdata), .s_wb_data_in(s_data),
    .s_wb_ack(s_ack), .s_wb_stall(s_stall),
    .err_addr(err_addr), .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [63:0] ref_base [NS] = '{64'h10000000, 64'h20400000};
  logic [63:0] ref_size [NS] = '{64'h00004000, 64'h00004000};
  logic [W-1:0] ref_err_addr = '0;

  function automatic int ref_decode(input logic [W-1:0] a);
    logic [63:0] aa;
    aa = {32'b0, a};
    for (int i = 0; i < NS; i++)
      if (aa >= ref_base[i] && aa < ref_base[i] + ref_size[i]) return i;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  // entry: {cycle[31:0], kind[1:0] (1=ack, 2=err), data[31:0]}
  logic [65:0] exp_q[$];
  logic [65:0] mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_ack || m_err) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d, none expected", m_ack, m_err, cyc_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_cycle", 64'(cyc_cnt), {32'b0, mon_e[65:34]});
          check("resp_kind", {62'b0, m_err, m_ack}, {62'b0, mon_e[33:32]});
          check("resp_data", {32'b0, m_rdata}, {32'b0, mon_e[31:0]});
        end
      end else begin
        check("idle_data_zero", {32'b0, m_rdata}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One full transaction: request, optional slave stall, slave ack after
  // ack_d cycles (ack_d > TO means it arrives too late and is stray).
  task automatic do_txn(input logic [W-1:0] addr, input logic we, input logic [W-1:0] rd,
                        input int stall_req, input int ack_d);
    int tgt, stall_n;
    longint t, end_c, last_c;
    logic [W-1:0] wd;
    logic [NS-1:0] oh;
    tgt = ref_decode(addr);
    stall_n = (tgt >= 0) ? stall_req : 0;
    wd = $urandom;
    for (int i = 0; i < NS; i++) s_data[i*W +: W] = $urandom;
    if (tgt >= 0) s_data[tgt*W +: W] = rd;
    oh = (tgt >= 0) ? (NS'(1) << tgt) : '0;
    m_stb = 1; m_cyc = 1; m_we = we; m_addr = addr; m_wdata = wd;
    for (int k = 0; k < stall_n; k++) begin
      s_stall = oh;
      @(negedge clk);
      check("stall_hi", {63'b0, m_stall}, 64'd1);
      check("stb_stalled", {62'b0, s_stb}, {62'b0, oh});
      @(posedge clk); #1;
    end
    s_stall = '0;
    t = cyc_cnt;
    @(negedge clk);
    check("stall_accept", {63'b0, m_stall}, 64'd0);
    check("stb_accept", {62'b0, s_stb}, {62'b0, oh});
    check("pass_addr", {32'b0, s_addr}, {32'b0, addr});
    check("pass_wdata", {32'b0, s_wdata}, {32'b0, wd});
    check("pass_we", {62'b0, s_cyc, s_we}, {62'b0, 1'b1, we});
    if (tgt < 0) begin
      end_c = t + 1;
      exp_q.push_back({32'(end_c), 2'd2, 32'd0});
      ref_err_addr = addr;
    end else if (ack_d >= 1 && ack_d <= TO) begin
      end_c = t + ack_d;
      exp_q.push_back({32'(end_c), 2'd1, rd});
    end else begin
      end_c = t + 1 + TO;
      exp_q.push_back({32'(end_c), 2'd2, 32'd0});
      ref_err_addr = addr;
    end
    last_c = (tgt >= 0 && t + ack_d > end_c) ? t + ack_d : end_c;
    @(posedge clk); #1;
    m_stb = 0;
    while (cyc_cnt <= last_c) begin
      s_ack = (tgt >= 0 && cyc_cnt == t + ack_d) ? oh : '0;
      @(negedge clk);
      check("stb_wait_zero", {62'b0, s_stb}, 64'd0);
      check("stall_wait", {63'b0, m_stall}, {63'b0, (cyc_cnt <= end_c)});
      @(posedge clk); #1;
    end
    s_ack = '0;
    m_cyc = 0;
    check("err_addr", {32'b0, err_addr}, {32'b0, ref_err_addr});
  endtask

  // Accept a request to slave 0, then drop cyc two cycles later while the
  // slave acks in that same cycle: nothing may reach the master.
  task automatic do_abort();
    m_stb = 1; m_cyc = 1; m_we = 0; m_addr = 32'h10000100;
    @(posedge clk); #1;               // T+1: waiting
    m_stb = 0;
    @(posedge clk); #1;               // T+2: cyc dropped, slave acks anyway
    m_cyc = 0;
    s_ack = 2'b01;
    @(negedge clk);
    check("abort_no_resp", {62'b0, m_ack, m_err}, 64'd0);
    @(posedge clk); #1;               // T+3
    s_ack = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, {63'b0, m_ack}, 64'd0);
    check({tag, "_err"}, {63'b0, m_err}, 64'd0);
    check({tag, "_data"}, {32'b0, m_rdata}, 64'd0);
    check({tag, "_stb"}, {62'b0, s_stb}, 64'd0);
    check({tag, "_err_addr"}, {32'b0, err_addr}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  logic [W-1:0] bnd [5] = '{32'h0FFFFFFC, 32'h10004000, 32'h203FFFFC, 32'h20404000, 32'h20403FFC};

  initial begin
    logic [W-1:0] a;
    // reset state
    #12;
    check_reset_outputs("reset");
    check("reset_stall_noreq", {63'b0, m_stall}, 64'd0);
    m_stb = 1; m_cyc = 1; m_addr = 32'h20400000; s_stall = 2'b10;
    #1;
    check("reset_stall_hit", {63'b0, m_stall}, 64'd1);
    check("reset_stb_gated", {62'b0, s_stb}, 64'd0);
    m_stb = 0; m_cyc = 0; s_stall = '0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // directed
    do_txn(32'h20400004, 1'b0, 32'hDEADBEEF, 0, 1);
    do_txn(32'h10000008, 1'b1, 32'h0, 3, 1);
    do_txn(32'h00000010, 1'b0, 32'h0, 0, 1);
    do_txn(32'h10004000, 1'b0, 32'h0, 0, 1);
    do_txn(32'h10003FFC, 1'b0, 32'h12345678, 0, 2);
    do_txn(32'h10000000, 1'b0, 32'h0, 0, TO + 2);   // timeout + stray ack
    do_txn(32'h10000004, 1'b0, 32'hCAFEF00D, 0, TO); // last counted cycle
    do_abort();
    do_txn(32'h20400010, 1'b0, 32'hA5A5A5A5, 0, 1);

    // reset in WAIT_ACK
    m_stb = 1; m_cyc = 1; m_we = 0; m_addr = 32'h20400020; s_data[W +: W] = 32'h11112222;
    @(posedge clk); #1;
    m_stb = 0;
    @(posedge clk); #2;
    rst_n = 0;
    ref_err_addr = '0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_stall", {63'b0, m_stall}, 64'd0);
    s_ack = 2'b10;
    #1;
    check("midreset_ack_blocked", {63'b0, m_ack}, 64'd0);
    s_ack = '0; m_cyc = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    do_txn(32'h20400000, 1'b0, 32'h0BADC0DE, 0, 1);

    // randomized
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h10000000 + ($urandom_range(0, 32'hFFF) << 2);
        1: a = 32'h20400000 + ($urandom_range(0, 32'hFFF) << 2);
        2: a = $urandom;
        default: a = bnd[$urandom_range(0, 4)];
      endcase
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), $urandom_range(1, TO + 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
